// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - Single-port synchronous RAM with request/ready handshake, wait states and post-reset clear
module ram_ctrl #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 8,
    parameter int DEPTH        = 256,
    parameter int WAIT_STATES  = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              init_done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_STATES);
    localparam state_t            RST_STATE = (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] ptr_q;
    logic [3:0]        wcnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] rdata_q;
    logic              ready_q;
    logic              err_q;

    logic addr_ok;
    logic req_ok;
    logic req_bad;
    logic access_now;

    // A request is only evaluated in IDLE; in CLEAR and ACCESS the inputs are ignored.
    assign addr_ok    = {1'b0, addr} < DEPTH_L;
    assign req_ok     = en & (read ^ write) & addr_ok;
    assign req_bad    = en & (read | write) & ~req_ok;
    assign access_now = (state_q == ST_ACCESS) && (wcnt_q == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RST_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: begin
                if (ptr_q == LAST_PTR) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (req_ok) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wcnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        init_done = 1'b1;
        case (state_q)
            ST_CLEAR: begin
                busy      = 1'b1;
                init_done = 1'b0;
            end
            ST_ACCESS: busy = 1'b1;
            default: begin
                busy      = 1'b0;
                init_done = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            wcnt_q  <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                ST_CLEAR: ptr_q <= ptr_q + 1'b1;
                ST_IDLE: begin
                    if (req_ok) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wr_q    <= write;
                        wcnt_q  <= WAIT_INIT;
                    end else if (req_bad) begin
                        err_q <= 1'b1;
                    end
                end
                ST_ACCESS: begin
                    if (wcnt_q != 4'd0) begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end else begin
                        ready_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= mem[addr_q];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset so it maps onto RAM; gating on rst drops an aborted write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem[ptr_q] <= '0;
            end else if (access_now && wr_q) begin
                mem[addr_q] <= wdata_q;
            end
        end
    end

    assign rdata = rdata_q;
    assign ready = ready_q;
    assign err   = err_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - Self-checking bench for ram_ctrl over three parameter sets
`timescale 1ns/1ps
module tb_ram_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]      rst_v = 3'b111;
    logic            en    = 1'b0;
    logic            read  = 1'b0;
    logic            write = 1'b0;
    logic [7:0]      addr  = 8'h00;
    logic [7:0]      wdata = 8'h00;
    logic [2:0][7:0] rdata_w;
    logic [2:0]      ready_w;
    logic [2:0]      busy_w;
    logic [2:0]      init_w;
    logic [2:0]      err_w;
    logic [1:0]      sel = 2'd0;

    logic [7:0] o_rdata;
    logic       o_ready;
    logic       o_busy;
    logic       o_init;
    logic       o_err;

    // Configs: 0 = clear, 1 wait; 1 = depth 200, 2 waits, no clear; 2 = no waits, no clear
    int ws_c    [3] = '{1, 2, 0};
    int depth_c [3] = '{256, 200, 256};

    logic [7:0] mm      [3][256];
    bit         vld     [3][256];
    logic [7:0] last_rd [3];

    int checks = 0;
    int errors = 0;

    ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(1), .CLEAR_ON_RST(1)) u_a (
        .clk(clk), .rst(rst_v[0]), .en(en), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .rdata(rdata_w[0]), .ready(ready_w[0]), .busy(busy_w[0]),
        .init_done(init_w[0]), .err(err_w[0]));

    ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_STATES(2), .CLEAR_ON_RST(0)) u_b (
        .clk(clk), .rst(rst_v[1]), .en(en), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .rdata(rdata_w[1]), .ready(ready_w[1]), .busy(busy_w[1]),
        .init_done(init_w[1]), .err(err_w[1]));

    ram_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_STATES(0), .CLEAR_ON_RST(0)) u_c (
        .clk(clk), .rst(rst_v[2]), .en(en), .read(read), .write(write), .addr(addr),
        .wdata(wdata), .rdata(rdata_w[2]), .ready(ready_w[2]), .busy(busy_w[2]),
        .init_done(init_w[2]), .err(err_w[2]));

    always_comb begin
        case (sel)
            2'd1: begin
                o_rdata = rdata_w[1]; o_ready = ready_w[1]; o_busy = busy_w[1];
                o_init  = init_w[1];  o_err   = err_w[1];
            end
            2'd2: begin
                o_rdata = rdata_w[2]; o_ready = ready_w[2]; o_busy = busy_w[2];
                o_init  = init_w[2];  o_err   = err_w[2];
            end
            default: begin
                o_rdata = rdata_w[0]; o_ready = ready_w[0]; o_busy = busy_w[0];
                o_init  = init_w[0];  o_err   = err_w[0];
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut(input int s);
        en    = 1'b0;
        read  = 1'b0;
        write = 1'b0;
        sel   = 2'(s);
        rst_v = 3'b111;
        repeat (3) tick();
        rst_v[s]   = 1'b0;
        last_rd[s] = 8'h00;
        if (s == 0) begin
            for (int i = 0; i < 256; i++) begin
                mm[0][i]  = 8'h00;
                vld[0][i] = 1'b1;
            end
        end
    endtask

    // Issues one request from IDLE, scrambles the inputs afterwards and observes 12 cycles.
    task automatic run_access(input bit wr, input bit rd, input logic [7:0] a, input logic [7:0] d,
                              output int lat, output int busy_n, output int err_n,
                              output int ready_n, output logic [7:0] rdv, output logic [7:0] rend);
        en    = 1'b1;
        read  = rd;
        write = wr;
        addr  = a;
        wdata = d;
        tick();
        en      = 1'($urandom_range(0, 1));
        read    = 1'b0;
        write   = 1'b0;
        addr    = 8'($urandom);
        wdata   = 8'($urandom);
        lat     = -1;
        busy_n  = 0;
        err_n   = 0;
        ready_n = 0;
        rdv     = 8'hxx;
        for (int i = 0; i < 12; i++) begin
            if (o_busy)  busy_n++;
            if (o_err)   err_n++;
            if (o_ready) begin
                ready_n++;
                if (lat < 0) begin
                    lat = i;
                    rdv = o_rdata;
                end
            end
            tick();
        end
        en   = 1'b0;
        rend = o_rdata;
    endtask

    task automatic test_reset();
        int n, bad, c;
        int lat, bn, en_n, rn;
        logic [7:0] rdv, rend;
        reset_dut(0);
        checks++;
        if ({o_busy, o_init, o_ready, o_err} !== 4'b1000)
            begin errors++; $display("FAIL reset_flags busy/init/ready/err got %b want 1000", {o_busy, o_init, o_ready, o_err}); end
        checks++;
        if (o_rdata !== 8'h00)
            begin errors++; $display("FAIL reset_rdata got %h want 00", o_rdata); end
        n = 0; bad = 0; c = 0;
        while (!o_init && c < 400) begin
            if (o_busy) n++;
            if (o_ready || o_err) bad++;
            c++;
            tick();
        end
        checks++;
        if (n !== 256)
            begin errors++; $display("FAIL clear_busy_cycles got %0d want 256", n); end
        checks++;
        if (o_init !== 1'b1 || o_busy !== 1'b0 || bad !== 0)
            begin errors++; $display("FAIL clear_done init %b busy %b stray pulses %0d want 1 0 0", o_init, o_busy, bad); end
        run_access(1'b0, 1'b1, 8'h7F, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (rn !== 1 || rdv !== 8'h00)
            begin errors++; $display("FAIL clear_read_7f ready %0d data %h want 1 00", rn, rdv); end
        run_access(1'b0, 1'b1, 8'hFF, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (rn !== 1 || rdv !== 8'h00)
            begin errors++; $display("FAIL clear_read_ff ready %0d data %h want 1 00", rn, rdv); end
        last_rd[0] = 8'h00;
    endtask

    task automatic test_wait_states();
        int lat, bn, en_n, rn;
        logic [7:0] rdv, rend;
        int w;
        w = ws_c[0];
        run_access(1'b1, 1'b0, 8'h10, 8'hA5, lat, bn, en_n, rn, rdv, rend);
        mm[0][8'h10] = 8'hA5;
        checks++;
        if (lat !== w + 1 || bn !== w + 1 || en_n !== 0 || rn !== 1)
            begin errors++; $display("FAIL ws_write lat %0d busy %0d err %0d ready %0d want %0d %0d 0 1", lat, bn, en_n, rn, w + 1, w + 1); end
        run_access(1'b0, 1'b1, 8'h10, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (lat !== w + 1 || bn !== w + 1 || en_n !== 0 || rn !== 1)
            begin errors++; $display("FAIL ws_read lat %0d busy %0d err %0d ready %0d want %0d %0d 0 1", lat, bn, en_n, rn, w + 1, w + 1); end
        checks++;
        if (rdv !== mm[0][8'h10])
            begin errors++; $display("FAIL ws_read_data got %h want %h", rdv, mm[0][8'h10]); end
        last_rd[0] = mm[0][8'h10];
    endtask

    task automatic test_reject();
        int lat, bn, en_n, rn;
        logic [7:0] rdv, rend, d;
        d = 8'($urandom);
        run_access(1'b1, 1'b0, 8'h20, d, lat, bn, en_n, rn, rdv, rend);
        mm[0][8'h20] = d;
        run_access(1'b1, 1'b1, 8'h20, ~d, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (en_n !== 1 || rn !== 0 || bn !== 0)
            begin errors++; $display("FAIL rej_rw err %0d ready %0d busy %0d want 1 0 0", en_n, rn, bn); end
        checks++;
        if (rend !== last_rd[0])
            begin errors++; $display("FAIL rej_rw_rdata got %h want %h", rend, last_rd[0]); end
        run_access(1'b0, 1'b1, 8'h20, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (rn !== 1 || rdv !== mm[0][8'h20])
            begin errors++; $display("FAIL rej_rw_prior ready %0d data %h want 1 %h", rn, rdv, mm[0][8'h20]); end
        last_rd[0] = mm[0][8'h20];

        reset_dut(1);
        run_access(1'b1, 1'b0, 8'h07, 8'h6E, lat, bn, en_n, rn, rdv, rend);
        mm[1][8'h07] = 8'h6E; vld[1][8'h07] = 1'b1;
        run_access(1'b0, 1'b1, 8'h07, 8'h00, lat, bn, en_n, rn, rdv, rend);
        last_rd[1] = 8'h6E;
        run_access(1'b1, 1'b0, 8'hC8, 8'h99, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (en_n !== 1 || rn !== 0 || bn !== 0)
            begin errors++; $display("FAIL rej_range err %0d ready %0d busy %0d want 1 0 0", en_n, rn, bn); end
        checks++;
        if (rend !== last_rd[1])
            begin errors++; $display("FAIL rej_range_rdata got %h want %h", rend, last_rd[1]); end
        run_access(1'b0, 1'b0, 8'hC8, 8'h99, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (en_n !== 0 || rn !== 0 || bn !== 0)
            begin errors++; $display("FAIL no_op err %0d ready %0d busy %0d want 0 0 0", en_n, rn, bn); end
    endtask

    task automatic test_reset_abort();
        int lat, bn, en_n, rn, seen;
        logic [7:0] rdv, rend;
        sel = 2'd1;
        run_access(1'b1, 1'b0, 8'h05, 8'h11, lat, bn, en_n, rn, rdv, rend);
        mm[1][8'h05] = 8'h11; vld[1][8'h05] = 1'b1;
        en = 1'b1; write = 1'b1; read = 1'b0; addr = 8'h05; wdata = 8'h3C;
        tick();
        en = 1'b0; write = 1'b0;
        checks++;
        if (o_busy !== 1'b1)
            begin errors++; $display("FAIL abort_accept busy %b want 1", o_busy); end
        seen = 0;
        tick();
        if (o_ready) seen++;
        rst_v[1] = 1'b1;
        tick();
        if (o_ready) seen++;
        rst_v[1]   = 1'b0;
        last_rd[1] = 8'h00;
        checks++;
        if (o_init !== 1'b1 || o_busy !== 1'b0 || o_rdata !== 8'h00)
            begin errors++; $display("FAIL abort_after_rst init %b busy %b rdata %h want 1 0 00", o_init, o_busy, o_rdata); end
        for (int i = 0; i < 4; i++) begin
            if (o_ready) seen++;
            tick();
        end
        checks++;
        if (seen !== 0)
            begin errors++; $display("FAIL abort_no_ready pulses %0d want 0", seen); end
        run_access(1'b0, 1'b1, 8'h05, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (rn !== 1 || rdv !== 8'h11)
            begin errors++; $display("FAIL abort_mem_kept ready %0d data %h want 1 11", rn, rdv); end
        last_rd[1] = 8'h11;
    endtask

    task automatic test_random();
        int lat, bn, en_n, rn, kind, w;
        bit wr, rd, rej;
        logic [7:0] a, d, rdv, rend;
        logic [7:0] wlist [$];
        w = ws_c[1];
        sel = 2'd1;
        wlist.push_back(8'h05);
        wlist.push_back(8'h07);
        for (int k = 0; k < 40; k++) begin
            a    = 8'($urandom_range(0, 255));
            d    = 8'($urandom);
            kind = $urandom_range(0, 3);
            wr   = (kind != 1);
            rd   = (kind == 1 || kind == 2);
            if (kind == 1 && $urandom_range(0, 1) == 1)
                a = wlist[$urandom_range(0, wlist.size() - 1)];
            if (kind == 1 && int'(a) < depth_c[1] && !vld[1][a]) begin
                wr = 1'b1; rd = 1'b0;
            end
            rej = (wr && rd) || (int'(a) >= depth_c[1]);
            run_access(wr, rd, a, d, lat, bn, en_n, rn, rdv, rend);
            if (rej) begin
                checks++;
                if (en_n !== 1 || rn !== 0 || bn !== 0)
                    begin errors++; $display("FAIL rnd_rej op %0d addr %h err %0d ready %0d busy %0d want 1 0 0", kind, a, en_n, rn, bn); end
                checks++;
                if (rend !== last_rd[1])
                    begin errors++; $display("FAIL rnd_rej_rdata addr %h got %h want %h", a, rend, last_rd[1]); end
            end else begin
                checks++;
                if (lat !== w + 1 || bn !== w + 1 || en_n !== 0 || rn !== 1)
                    begin errors++; $display("FAIL rnd_timing addr %h lat %0d busy %0d err %0d ready %0d want %0d %0d 0 1", a, lat, bn, en_n, rn, w + 1, w + 1); end
                if (rd) begin
                    checks++;
                    if (rdv !== mm[1][a])
                        begin errors++; $display("FAIL rnd_read addr %h got %h want %h", a, rdv, mm[1][a]); end
                    last_rd[1] = mm[1][a];
                end else begin
                    mm[1][a]  = d;
                    vld[1][a] = 1'b1;
                    wlist.push_back(a);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         q_wr [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] q_a  [4] = '{8'h00, 8'h01, 8'h00, 8'h01};
        logic [7:0] q_d  [4] = '{8'h01, 8'h02, 8'h00, 8'h00};
        int         cyc  [8];
        logic [7:0] rv   [8];
        int idx, nr, bad;
        bit prev_busy;
        reset_dut(2);
        idx = 0; nr = 0; bad = 0; prev_busy = 1'b0;
        en = 1'b1; write = q_wr[0]; read = ~q_wr[0]; addr = q_a[0]; wdata = q_d[0];
        for (int c = 0; c < 24; c++) begin
            tick();
            if (o_err) bad++;
            if (o_ready && nr < 8) begin
                cyc[nr] = c;
                rv[nr]  = o_rdata;
                nr++;
            end
            if (o_busy && !prev_busy) begin
                idx++;
                if (idx < 4) begin
                    write = q_wr[idx]; read = ~q_wr[idx]; addr = q_a[idx]; wdata = q_d[idx];
                end else begin
                    en = 1'b0; write = 1'b0; read = 1'b0;
                end
            end
            prev_busy = o_busy;
        end
        en = 1'b0;
        checks++;
        if (nr !== 4 || bad !== 0)
            begin errors++; $display("FAIL b2b_count ready %0d err %0d want 4 0", nr, bad); end
        if (nr == 4) begin
            for (int i = 1; i < 4; i++) begin
                checks++;
                if (cyc[i] - cyc[i-1] !== ws_c[2] + 2)
                    begin errors++; $display("FAIL b2b_spacing idx %0d got %0d want %0d", i, cyc[i] - cyc[i-1], ws_c[2] + 2); end
            end
            checks++;
            if (rv[2] !== 8'h01 || rv[3] !== 8'h02)
                begin errors++; $display("FAIL b2b_data got %h %h want 01 02", rv[2], rv[3]); end
        end
    endtask

    task automatic test_clear_requests();
        int bad, c, rn, lat, bn, en_n;
        logic [7:0] rdv, rend;
        reset_dut(0);
        en = 1'b1; write = 1'b1; read = 1'b0; addr = 8'h30; wdata = 8'h5A;
        bad = 0; c = 0;
        while (!o_init && c < 400) begin
            if (o_ready || o_err) bad++;
            c++;
            tick();
        end
        checks++;
        if (bad !== 0 || o_init !== 1'b1)
            begin errors++; $display("FAIL clear_ignore stray pulses %0d init %b want 0 1", bad, o_init); end
        rn = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_busy) begin en = 1'b0; write = 1'b0; end
            if (o_ready) rn++;
            if (o_err) bad++;
        end
        en = 1'b0; write = 1'b0;
        mm[0][8'h30] = 8'h5A;
        checks++;
        if (rn !== 1 || bad !== 0)
            begin errors++; $display("FAIL clear_held_req ready %0d err %0d want 1 0", rn, bad); end
        run_access(1'b0, 1'b1, 8'h30, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (rdv !== mm[0][8'h30])
            begin errors++; $display("FAIL clear_held_data got %h want %h", rdv, mm[0][8'h30]); end
        run_access(1'b0, 1'b1, 8'h10, 8'h00, lat, bn, en_n, rn, rdv, rend);
        checks++;
        if (rdv !== mm[0][8'h10])
            begin errors++; $display("FAIL clear_recleared got %h want %h", rdv, mm[0][8'h10]); end
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 256; i++) begin
                mm[s][i]  = 8'h00;
                vld[s][i] = 1'b0;
            end
            last_rd[s] = 8'h00;
        end
        test_reset();
        test_wait_states();
        test_reject();
        test_reset_abort();
        test_random();
        test_back_to_back();
        test_clear_requests();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
